// File: rtl/led_matrix_scanner_if.sv
// Pin-side bundle for led_matrix_scanner: serial pixel input, scan enable and
// the row/column drive outputs.
interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic            ena;
  logic            din;
  logic            dclk;
  logic            strobe;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_sel;
  logic            frame_start;
  logic            pending;

  modport master (
    output ena, din, dclk, strobe,
    input  row_out, col_sel, frame_start, pending
  );

  modport slave (
    input  ena, din, dclk, strobe,
    output row_out, col_sel, frame_start, pending
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Parametrised LED-matrix scanner: serial shift-in, strobe capture, tear-free
// frame-boundary load and blanked column scanning.
// Define LED_MATRIX_ACTIVE_LOW_COL_EN for an active-low col_sel.
module led_matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 256,
  parameter int BLANK_CYCLES = 32,
  parameter int SYNC_STAGES  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  led_matrix_scanner_if.slave bus
);

  localparam int N            = ROWS * COLS;
  localparam int DRIVE_CYCLES = DWELL_CYCLES - BLANK_CYCLES;
  localparam int CNT_W        = $clog2(DWELL_CYCLES);
  localparam int COL_W        = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

`ifdef LED_MATRIX_ACTIVE_LOW_COL_EN
  localparam logic COL_INV = 1'b1;
`else
  localparam logic COL_INV = 1'b0;
`endif
  localparam logic [COLS-1:0] COL_IDLE = {COLS{COL_INV}};

  typedef enum logic {BLANK, DRIVE} phase_e;

  typedef struct packed {
    phase_e           phase;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] cnt;
    logic             run;   // 0 until the first enabled edge opens a frame
  } scan_t;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] din_sync, dclk_sync, strobe_sync;
  logic                   dclk_d, strobe_d;
  logic                   din_s, dclk_rise, strobe_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_sync    <= '0;
      dclk_sync   <= '0;
      strobe_sync <= '0;
      dclk_d      <= 1'b0;
      strobe_d    <= 1'b0;
    end else begin
      din_sync    <= {din_sync[SYNC_STAGES-2:0], bus.din};
      dclk_sync   <= {dclk_sync[SYNC_STAGES-2:0], bus.dclk};
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.strobe};
      dclk_d      <= dclk_sync[SYNC_STAGES-1];
      strobe_d    <= strobe_sync[SYNC_STAGES-1];
    end
  end

  assign din_s       = din_sync[SYNC_STAGES-1];
  assign dclk_rise   = dclk_sync[SYNC_STAGES-1] & ~dclk_d;
  assign strobe_rise = strobe_sync[SYNC_STAGES-1] & ~strobe_d;

  // ---------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------
  scan_t state_q, state_d;
  logic  boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '{phase: BLANK, col: '0, cnt: '0, run: 1'b0};
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    boundary = 1'b0;
    if (!bus.ena) begin
      state_d = '{phase: BLANK, col: '0, cnt: '0, run: 1'b0};
    end else if (!state_q.run) begin
      state_d  = '{phase: BLANK, col: '0, cnt: '0, run: 1'b1};
      boundary = 1'b1;
    end else if (state_q.phase == BLANK) begin
      if (state_q.cnt == BLANK_LAST) begin
        state_d.phase = DRIVE;
        state_d.cnt   = '0;
      end else begin
        state_d.cnt = state_q.cnt + CNT_W'(1);
      end
    end else begin
      if (state_q.cnt == DRIVE_LAST) begin
        state_d.phase = BLANK;
        state_d.cnt   = '0;
        if (state_q.col == COL_LAST) begin
          state_d.col = '0;
          boundary    = 1'b1;
        end else begin
          state_d.col = state_q.col + COL_W'(1);
        end
      end else begin
        state_d.cnt = state_q.cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Input chain, shadow capture and display buffer
  // ---------------------------------------------------------------------
  logic [N-1:0] chain, shadow, vbuf;
  logic         pending_q;

  // NOTE: the pixel buffers are plain registers, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= '0;
      shadow    <= '0;
      vbuf      <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean a same-cycle capture sees the pre-shift chain.
      if (dclk_rise) chain <= {chain[N-2:0], din_s};
      // A capture in the boundary cycle wins; the fresh shadow loads one frame later.
      if (strobe_rise) begin
        shadow    <= chain;
        pending_q <= 1'b1;
      end else if (boundary && pending_q) begin
        vbuf      <= shadow;
        pending_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [ROWS-1:0] row_q;
  logic [COLS-1:0] col_q;
  logic            fs_q;
  logic [COLS-1:0] col_onehot;

  assign col_onehot = COLS'(1) << state_d.col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= COL_IDLE;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= boundary;
      if (state_d.phase == DRIVE) begin
        row_q <= vbuf[int'(state_d.col) * ROWS +: ROWS];
        col_q <= col_onehot ^ COL_IDLE;
      end else begin
        row_q <= '0;
        col_q <= COL_IDLE;
      end
    end
  end

  assign bus.row_out     = row_q;
  assign bus.col_sel     = col_q;
  assign bus.frame_start = fs_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: random pixel frames against a
// frame-position reference model, plus directed boundary scenarios.
module tb_led_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DWELL = 256;
  localparam int BLANK = 32;
  localparam int S     = 2;
  localparam int N     = ROWS * COLS;
  localparam int FRAME = COLS * DWELL;

`ifdef LED_MATRIX_ACTIVE_LOW_COL_EN
  localparam logic [COLS-1:0] IDLE = '1;
`else
  localparam logic [COLS-1:0] IDLE = '0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK), .SYNC_STAGES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [S+1:0]  h_din, h_dclk, h_strb;  // pin samples, [j] = j edges ago
  bit            recv[$];                // last N bits shifted in, newest at back
  bit            shad[N];
  bit            vis[N];
  bit            m_pend, m_run;
  int            m_p;                    // position within the frame
  logic [ROWS-1:0] e_row;
  logic [COLS-1:0] e_col;
  logic            e_fs;

  function automatic void model_reset();
    recv.delete();
    for (int i = 0; i < N; i++) begin
      recv.push_back(1'b0);
      shad[i] = 1'b0;
      vis[i]  = 1'b0;
    end
    h_din = '0; h_dclk = '0; h_strb = '0;
    m_pend = 1'b0; m_run = 1'b0; m_p = 0;
    e_row = '0; e_col = IDLE; e_fs = 1'b0;
  endfunction

  function automatic void model_edge();
    logic dr, sr, ds;
    bit   bnd;
    int   c;
    h_din  = {h_din[S:0],  bus.din};
    h_dclk = {h_dclk[S:0], bus.dclk};
    h_strb = {h_strb[S:0], bus.strobe};
    dr = h_dclk[S] & ~h_dclk[S+1];
    sr = h_strb[S] & ~h_strb[S+1];
    ds = h_din[S];
    bnd = 1'b0;
    if (!bus.ena) begin
      m_run = 1'b0; m_p = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_p = 0; bnd = 1'b1;
    end else begin
      m_p = (m_p + 1) % FRAME;
      bnd = (m_p == 0);
    end
    if (sr) begin
      for (int i = 0; i < N; i++) shad[i] = recv[N-1-i];
      m_pend = 1'b1;
    end else if (bnd && m_pend) begin
      vis = shad;
      m_pend = 1'b0;
    end
    if (dr) begin
      recv.push_back(ds);
      void'(recv.pop_front());
    end
    e_fs = bnd;
    if (bus.ena && (m_p % DWELL) >= BLANK) begin
      c = m_p / DWELL;
      e_col = (COLS'(1) << c) ^ IDLE;
      for (int r = 0; r < ROWS; r++) e_row[r] = vis[c*ROWS + r];
    end else begin
      e_row = '0;
      e_col = IDLE;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    check("outputs", {14'd0, bus.row_out, bus.col_sel, bus.frame_start, bus.pending},
                     {14'd0, e_row, e_col, e_fs, m_pend});
  endtask

  task automatic send_bit(input logic b);
    bus.din  = b;
    bus.dclk = 1'b0;
    repeat (4) step();
    bus.dclk = 1'b1;
    repeat (4) step();
  endtask

  task automatic send_frame(input logic [N-1:0] pat);
    for (int i = N-1; i >= 0; i--) send_bit(pat[i]);
  endtask

  task automatic pulse_strobe();
    bus.strobe = 1'b1;
    repeat (4) step();
    bus.strobe = 1'b0;
    repeat (4) step();
  endtask

  task automatic wait_fs(input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (bus.frame_start !== 1'b1 && k < FRAME + 16);
    check(tag, {31'd0, bus.frame_start}, 32'd1);
  endtask

  task automatic wait_pos(input string tag, input int target);
    int k = 0;
    do begin
      step();
      k++;
    end while (m_p != target && k < FRAME + 16);
    check(tag, (k < FRAME + 16) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [N-1:0] pat;
  int           k;

  initial begin
    bus.ena = 1'b1; bus.din = 1'b0; bus.dclk = 1'b0; bus.strobe = 1'b0;
    model_reset();

    // Reset state and first frame after release
    repeat (3) step();
    check("rst_row", {24'd0, bus.row_out}, 32'h0);
    check("rst_col", {24'd0, bus.col_sel}, {24'd0, IDLE});
    check("rst_pend", {31'd0, bus.pending}, 32'd0);
    rst_n = 1'b1;
    step();
    check("first_fs", {31'd0, bus.frame_start}, 32'd1);

    // Load 0x80 in every column and scan
    pat = {COLS{8'h80}};
    send_frame(pat);
    pulse_strobe();
    check("load_pend", {31'd0, bus.pending}, 32'd1);
    wait_fs("load_fs");
    check("load_pend_clr", {31'd0, bus.pending}, 32'd0);
    repeat (BLANK) step();
    check("c0_row", {24'd0, bus.row_out}, 32'h80);
    check("c0_col", {24'd0, bus.col_sel}, {24'd0, 8'h01 ^ IDLE});
    repeat (2*DWELL) step();
    check("c2_row", {24'd0, bus.row_out}, 32'h80);
    check("c2_col", {24'd0, bus.col_sel}, {24'd0, 8'h04 ^ IDLE});
    k = 2*DWELL + BLANK;
    do begin
      step();
      k++;
    end while (bus.frame_start !== 1'b1 && k < FRAME + 16);
    check("frame_period", k, FRAME);

    // Tear-free updates with random patterns strobed mid-frame
    for (int it = 0; it < 2; it++) begin
      pat = {$urandom(), $urandom()};
      send_frame(pat);
      wait_pos("tf_pos", FRAME/2);
      pulse_strobe();
      check("tf_pend", {31'd0, bus.pending}, 32'd1);
      wait_fs("tf_fs");
      check("tf_pend_clr", {31'd0, bus.pending}, 32'd0);
      repeat (BLANK) step();
      check("tf_row", {24'd0, bus.row_out}, {24'd0, pat[7:0]});
    end

    // dclk and strobe rises detected in the same cycle
    pat = {$urandom(), $urandom()};
    send_frame(pat);
    wait_pos("sim_pos", FRAME/4);
    bus.dclk = 1'b0; bus.din = 1'b1;
    repeat (4) step();
    bus.dclk = 1'b1; bus.strobe = 1'b1;
    repeat (4) step();
    bus.dclk = 1'b0; bus.strobe = 1'b0;
    repeat (4) step();
    wait_fs("sim_fs");
    repeat (BLANK) step();
    check("sim_row_c0", {24'd0, bus.row_out}, {24'd0, pat[7:0]});
    repeat (DWELL) step();
    check("sim_row_c1", {24'd0, bus.row_out}, {24'd0, pat[15:8]});

    // Strobe landing in the frame-boundary cycle
    pat = {$urandom(), $urandom()};
    send_frame(pat);
    check("bnd_pend_pre", {31'd0, bus.pending}, 32'd0);
    wait_pos("bnd_pos", FRAME - 1 - S);
    bus.strobe = 1'b1;
    repeat (S+1) step();
    check("bnd_fs", {31'd0, bus.frame_start}, 32'd1);
    check("bnd_pend", {31'd0, bus.pending}, 32'd1);
    bus.strobe = 1'b0;
    wait_fs("bnd_fs2");
    check("bnd_pend_clr", {31'd0, bus.pending}, 32'd0);
    repeat (BLANK) step();
    check("bnd_row", {24'd0, bus.row_out}, {24'd0, pat[7:0]});

    // Enable dropped while shifting and strobing
    bus.ena = 1'b0;
    pat = {$urandom(), $urandom()};
    send_frame(pat);
    pulse_strobe();
    check("dis_pend", {31'd0, bus.pending}, 32'd1);
    check("dis_row", {24'd0, bus.row_out}, 32'h0);
    check("dis_col", {24'd0, bus.col_sel}, {24'd0, IDLE});
    bus.ena = 1'b1;
    step();
    check("en_fs", {31'd0, bus.frame_start}, 32'd1);
    check("en_pend", {31'd0, bus.pending}, 32'd0);
    repeat (BLANK) step();
    check("en_row", {24'd0, bus.row_out}, {24'd0, pat[7:0]});

    // Asynchronous reset in the middle of DRIVE with a capture pending
    pulse_strobe();
    check("pre_rst_pend", {31'd0, bus.pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_row", {24'd0, bus.row_out}, 32'h0);
    check("arst_col", {24'd0, bus.col_sel}, {24'd0, IDLE});
    check("arst_pend", {31'd0, bus.pending}, 32'd0);
    bus.dclk = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("arst_first_fs", {31'd0, bus.frame_start}, 32'd1);
    repeat (BLANK + 4) step();
    check("arst_row_blank_buf", {24'd0, bus.row_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised LED-matrix scanner: serial pixel data is shifted in on a slow external data clock, captured on a strobe, and then displayed by time-multiplexed column scanning with a programmable blanking (de-ghosting) interval. It is the next-generation successor of the fixed 8×8 driver. Everything runs in the single `clk` domain, and `dclk`/`strobe` are synchronised. Display updates are tear-free and occur only at frame boundaries. It sits between the chip's dedicated input pins and the row/column output pads.

## Interface
- `ROWS`, default 8: rows per column; width of `row_out`.
- `COLS`, default 8: columns scanned; width of `col_sel`.
- `DWELL_CYCLES`, default 256: `clk` cycles per column slot, blanking included. Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 32: cycles at the start of each slot with all outputs off. Must be at least 1.
- `SYNC_STAGES`, default 2: synchroniser depth for `din`, `dclk` and `strobe`. Must be at least 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: scan enable.
- `din`  in  1: serial pixel data.
- `dclk`  in  1: data shift clock, asynchronous to `clk`.
- `strobe`  in  1: capture request, asynchronous to `clk`.
- `row_out`  out  ROWS: row drive for the active column; 1 = LED on.
- `col_sel`  out  COLS: one-hot column select.
- `frame_start`  out  1: one-cycle pulse at the start of each frame.
- `pending`  out  1: a captured frame is waiting to be displayed.

## Operation
- **Synchronisers.** `din`, `dclk` and `strobe` each pass through `SYNC_STAGES` flops. One further flop on `dclk`/`strobe` provides rising-edge detection.
- **Input chain.** The chain is N = ROWS*COLS bits. On a detected `dclk` rise: `chain <= {chain[N-2:0], din_s}`.
  - Bit index i = c*ROWS + r.
  - After N shifts, the first bit sent is displayed at column COLS-1, row ROWS-1.
- **Capture.** On a detected `strobe` rise, `shadow <= chain` and `pending <= 1`.
  - If a `dclk` rise is detected in the same cycle, `shadow` receives the pre-shift chain.
  - A second strobe before the frame boundary overwrites `shadow`; it is not queued.
- **Display load.** At each frame boundary (entry to BLANK of column 0), if `pending` = 1 then `vbuf <= shadow` and `pending <= 0`.
  - If a strobe capture lands in the boundary cycle itself, the capture wins: `pending` stays 1, and the new `shadow` loads at the next boundary.
- **Scan FSM.** The state is {phase ∈ BLANK/DRIVE, col ∈ 0..COLS-1, cnt}.
  - BLANK: hold for `BLANK_CYCLES`; `row_out` = 0, `col_sel` = 0.
  - DRIVE: hold for `DWELL_CYCLES - BLANK_CYCLES`; `col_sel` = one-hot(col), `row_out` = `vbuf[col*ROWS +: ROWS]`.
  - After DRIVE, `col` increments and wraps from COLS-1 to 0, and the FSM returns to BLANK.
  - `frame_start` pulses for one cycle when entering BLANK with col = 0.
- **Enable.** With `ena` = 0 the scan FSM is forced to BLANK, col 0, cnt 0, and all outputs are off. The input chain, capture and `pending` keep operating.
  - When `ena` rises, the first frame starts on the next cycle with a `frame_start` pulse, and any pending load happens then.
- **Reset.** All registers are cleared: `chain`, `shadow`, `vbuf`, `pending`, FSM (BLANK, col 0, cnt 0), `row_out` = 0, `col_sel` = 0, `frame_start` = 0.
  - Reset asserted mid-frame or mid-shift blanks the outputs immediately (asynchronously).
  - After `rst_n` rises, the first `frame_start` occurs on the first `clk` edge with `ena` = 1.

## Timing
- All outputs are registered.
- `dclk`/`strobe` pin rise to effect: SYNC_STAGES+1 `clk` edges.
- `dclk` high and low phases must each last at least SYNC_STAGES+1 `clk` periods.
- `din` must be stable for SYNC_STAGES+1 `clk` periods around each `dclk` rise.
- Column slot = `DWELL_CYCLES`; frame = COLS*DWELL_CYCLES (2048 clk at defaults). The duty cycle per LED is (DWELL-BLANK)/(COLS*DWELL).
- Strobe-to-display latency is at most one frame plus the synchroniser delay.

## Configuration
- `LED_MATRIX_ACTIVE_LOW_COL_EN`: when defined, `col_sel` is inverted at the output register.
  - Selected column = 0; idle, blank and reset value = all ones.
- When undefined, `col_sel` is active-high and its idle/reset value is all zeros.
- `row_out` polarity is unaffected in both cases.

## Test plan
- **Reset:** hold `rst_n` = 0 mid-DRIVE -> `row_out` = 0x00, `col_sel` = 0x00 and `pending` = 0 immediately; the first `frame_start` comes one clk after release with `ena` = 1.
- **Load and scan:** shift 64 bits forming 0x80 in each column byte, then strobe -> from the next frame, each column drives `row_out` = 0x80 for 224 cycles after 32 blank cycles, with `col_sel` stepping 0x01…0x80 and the frame repeating every 2048 cycles.
- **Tear-free update:** strobe a new pattern mid-frame -> the old `vbuf` is displayed until the next `frame_start`, and `pending` = 1 until that cycle.
- **Simultaneous events:** synchronised `dclk` and `strobe` rises detected in the same cycle -> `shadow` equals the pre-shift chain. A strobe landing in the frame-boundary cycle -> `pending` stays 1 and the new data appears one frame later.
- **Enable:** drop `ena` for 500 cycles while shifting and strobing -> outputs stay off and `pending` = 1; on re-enable, `frame_start` fires and the new pattern is displayed.
- **Macro:** with `LED_MATRIX_ACTIVE_LOW_COL_EN` defined -> reset/blank `col_sel` = 0xFF and column 2 drive = 0xFB.
